backbone_initial_packer: RTL and testbench



---
 rtl/backbone_initial_packer_if.sv | 23 ++
 rtl/backbone_initial_packer.sv | 115 +++++++++++
 tb/tb_backbone_initial_packer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/backbone_initial_packer_if.sv
// Slot-beat stream into the backbone initial packer.
// Master drives alpha/x beats, slave returns s_tready.
interface backbone_initial_packer_if #(
    parameter int A = 2
);
    localparam int A_WIDTH = $clog2(A) + 1;

    logic [A*64-1:0]    s_alpha;
    logic [A_WIDTH-1:0] s_x;
    logic               s_tvalid;
    logic               s_tlast;
    logic               s_tready;

    modport master (
        output s_alpha, s_x, s_tvalid, s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_alpha, s_x, s_tvalid, s_tlast,
        output s_tready
    );
endinterface

// File: rtl/backbone_initial_packer.sv
// Packs up to J alpha/x slot beats into one frame with a one-cycle valid pulse.
// Define BACKBONE_PACKER_XCHK_EN to clamp out-of-range s_x to 0 and flag x_err.
module backbone_initial_packer #(
    parameter int J = 14,
    parameter int A = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    backbone_initial_packer_if.slave s,
    input  logic                     backbone_initial_tvalid,
    output logic [J*A*64-1:0]        alpha_u,
    output logic                     alpha_u_tvalid,
    output logic [J*($clog2(A)+1)-1:0] x_initial,
    output logic                     x_initial_tvalid,
    output logic [$clog2(J):0]       ind_j,
    output logic                     ind_j_tvalid,
    output logic                     x_err
);
    localparam int J_WIDTH = $clog2(J) + 1;
    localparam int A_WIDTH = $clog2(A) + 1;

    typedef enum logic [1:0] {COLLECT, EMIT, WAIT} state_t;

    state_t               state, state_nxt;
    logic [J_WIDTH-1:0]   cnt;
    logic [J*A*64-1:0]    slot_alpha, alpha_nxt;
    logic [J*A_WIDTH-1:0] slot_x, x_nxt;
    logic [A_WIDTH-1:0]   x_in;
    logic                 x_bad;
    logic                 accept;
    logic                 last_beat;

    // Ready is gated by rst so it stays low for the whole reset window.
    assign s.s_tready = (state == COLLECT) && !rst;
    assign accept     = s.s_tvalid && s.s_tready;
    assign last_beat  = accept && (s.s_tlast || cnt == J_WIDTH'(J - 1));

    assign alpha_u_tvalid   = (state == EMIT);
    assign x_initial_tvalid = (state == EMIT);
    assign ind_j_tvalid     = (state == EMIT);

`ifdef BACKBONE_PACKER_XCHK_EN
    assign x_bad = (s.s_x >= A_WIDTH'(A));
    assign x_in  = x_bad ? '0 : s.s_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            x_err <= 1'b0;
        else if (accept && x_bad)
            x_err <= 1'b1;
    end
`else
    assign x_bad = 1'b0;
    assign x_in  = s.s_x;
    assign x_err = x_bad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (last_beat) state_nxt = EMIT;
            EMIT:    state_nxt = WAIT;
            WAIT:    if (backbone_initial_tvalid) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Slot image including the beat currently on the bus.
    always_comb begin
        alpha_nxt = slot_alpha;
        x_nxt     = slot_x;
        for (int j = 0; j < J; j++) begin
            if (cnt == J_WIDTH'(j)) begin
                alpha_nxt[j*A*64 +: A*64]      = s.s_alpha;
                x_nxt[j*A_WIDTH +: A_WIDTH]    = x_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            slot_alpha <= '0;
            slot_x     <= '0;
            alpha_u    <= '0;
            x_initial  <= '0;
            ind_j      <= '0;
        end else if (accept) begin
            if (cnt == '0) begin
                alpha_u   <= '0;
                x_initial <= '0;
                ind_j     <= '0;
            end
            if (last_beat) begin
                alpha_u    <= alpha_nxt;
                x_initial  <= x_nxt;
                ind_j      <= cnt + J_WIDTH'(1);
                slot_alpha <= '0;
                slot_x     <= '0;
                cnt        <= '0;
            end else begin
                slot_alpha <= alpha_nxt;
                slot_x     <= x_nxt;
                cnt        <= cnt + J_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_backbone_initial_packer.sv
// Scoreboard bench for backbone_initial_packer: directed frames, monitor pops
// expected frames whenever the DUT pulses its frame-valid outputs.
module tb_backbone_initial_packer;
    localparam int J  = 14;
    localparam int A  = 2;
    localparam int JW = 5;
    localparam int AW = 2;
`ifdef BACKBONE_PACKER_XCHK_EN
    localparam logic XCHK = 1'b1;
`else
    localparam logic XCHK = 1'b0;
`endif

    typedef struct packed {
        logic [JW-1:0]     n;
        logic [J*A*64-1:0] alpha;
        logic [J*AW-1:0]   x;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;
    logic [J*A*64-1:0] alpha_u;
    logic [J*AW-1:0]   x_initial;
    logic [JW-1:0]     ind_j;
    logic alpha_u_tvalid, x_initial_tvalid, ind_j_tvalid, x_err;

    int n_vec = 0;
    int n_err = 0;
    frame_t exp_q[$];

    backbone_initial_packer_if #(.A(A)) ifc ();

    backbone_initial_packer #(.J(J), .A(A)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s                       (ifc),
        .backbone_initial_tvalid (done),
        .alpha_u                 (alpha_u),
        .alpha_u_tvalid          (alpha_u_tvalid),
        .x_initial               (x_initial),
        .x_initial_tvalid        (x_initial_tvalid),
        .ind_j                   (ind_j),
        .ind_j_tvalid            (ind_j_tvalid),
        .x_err                   (x_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic frame_t put(input frame_t f, input int j,
                                   input real a0, input real a1, input logic [1:0] x);
        f.alpha[(j*2)*64 +: 64]   = $realtobits(a0);
        f.alpha[(j*2+1)*64 +: 64] = $realtobits(a1);
        f.x[j*2 +: 2]             = x;
        return f;
    endfunction

    task automatic send(input real a0, input real a1, input logic [1:0] x, input logic last);
        int t = 0;
        @(negedge clk);
        ifc.s_alpha  = {$realtobits(a1), $realtobits(a0)};
        ifc.s_x      = x;
        ifc.s_tlast  = last;
        ifc.s_tvalid = 1'b1;
        while (!ifc.s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ifc.s_tready) chk("beat_accept_timeout", 64'(ifc.s_tready), 64'd1);
        @(posedge clk);
        #1;
        ifc.s_tvalid = 1'b0;
        ifc.s_tlast  = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic monitor();
        frame_t e;
        forever begin
            @(negedge clk);
            if (!rst && (alpha_u_tvalid || x_initial_tvalid || ind_j_tvalid)) begin
                chk("tvalid_coincident",
                    64'({alpha_u_tvalid, x_initial_tvalid, ind_j_tvalid}), 64'd7);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got ind_j=%0d, want no pulse", ind_j);
                end else begin
                    e = exp_q.pop_front();
                    chk("ind_j", 64'(ind_j), 64'(e.n));
                    for (int j = 0; j < J; j++) begin
                        chk($sformatf("alpha_s%0d_e0", j), alpha_u[(j*2)*64 +: 64],
                            e.alpha[(j*2)*64 +: 64]);
                        chk($sformatf("alpha_s%0d_e1", j), alpha_u[(j*2+1)*64 +: 64],
                            e.alpha[(j*2+1)*64 +: 64]);
                        chk($sformatf("x_s%0d", j), 64'(x_initial[j*2 +: 2]),
                            64'(e.x[j*2 +: 2]));
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        frame_t f;
        ifc.s_alpha  = '0;
        ifc.s_x      = '0;
        ifc.s_tvalid = 1'b0;
        ifc.s_tlast  = 1'b0;
        fork
            monitor();
        join_none

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ifc.s_tready), 64'd0);
        chk("rst_ind_j", 64'(ind_j), 64'd0);
        chk("rst_tvalid", 64'(alpha_u_tvalid), 64'd0);
        chk("rst_x_err", 64'(x_err), 64'd0);
        chk("rst_alpha_nz", 64'(|alpha_u), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(ifc.s_tready), 64'd1);

        // four beats, tlast on the fourth
        f = '0;
        f.n = 5'd4;
        for (int j = 0; j < 4; j++)
            f = put(f, j, real'(2*j+1), real'(2*j+2), 2'(j % 2));
        exp_q.push_back(f);
        for (int j = 0; j < 4; j++)
            send(real'(2*j+1), real'(2*j+2), 2'(j % 2), j == 3);
        chk("emit_latency_hi", 64'(alpha_u_tvalid), 64'd1);
        @(posedge clk);
        #1;
        chk("emit_latency_lo", 64'(alpha_u_tvalid), 64'd0);
        repeat (4) @(negedge clk);
        chk("wait_ready_low", 64'(ifc.s_tready), 64'd0);
        chk("wait_ind_j_hold", 64'(ind_j), 64'd4);
        chk("wait_alpha_s3_hold", alpha_u[7*64 +: 64], $realtobits(8.0));
        done_pulse();
        chk("ready_after_done", 64'(ifc.s_tready), 64'd1);

        // fourteen beats auto-terminate, fifteenth held off
        f = '0;
        f.n = 5'd14;
        for (int j = 0; j < 14; j++)
            f = put(f, j, real'(100+j), real'(200+j), 2'(j % 2));
        exp_q.push_back(f);
        for (int j = 0; j < 14; j++)
            send(real'(100+j), real'(200+j), 2'(j % 2), 1'b0);
        f = '0;
        f.n = 5'd1;
        f = put(f, 0, 55.5, -3.25, 2'd1);
        exp_q.push_back(f);
        ifc.s_alpha  = {$realtobits(-3.25), $realtobits(55.5)};
        ifc.s_x      = 2'd1;
        ifc.s_tlast  = 1'b1;
        ifc.s_tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("beat15_held", 64'(ifc.s_tready), 64'd0);
        end
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        @(posedge clk);
        #1;
        ifc.s_tvalid = 1'b0;
        ifc.s_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        done_pulse();

        // done pulse during COLLECT is ignored
        f = '0;
        f.n = 5'd2;
        f = put(f, 0, 1.5, 2.5, 2'd0);
        f = put(f, 1, 3.5, 4.5, 2'd1);
        exp_q.push_back(f);
        send(1.5, 2.5, 2'd0, 1'b0);
        done_pulse();
        send(3.5, 4.5, 2'd1, 1'b1);
        repeat (5) @(negedge clk);
        chk("stay_wait", 64'(ifc.s_tready), 64'd0);
        done_pulse();
        chk("leave_wait", 64'(ifc.s_tready), 64'd1);

        // reset mid-frame discards partial frame
        for (int j = 0; j < 3; j++)
            send(real'(9+j), real'(19+j), 2'd1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(ifc.s_tready), 64'd0);
        chk("midrst_ind_j", 64'(ind_j), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        f = '0;
        f.n = 5'd2;
        f = put(f, 0, 7.0, 8.0, 2'd0);
        f = put(f, 1, 9.0, 10.0, 2'd1);
        exp_q.push_back(f);
        send(7.0, 8.0, 2'd0, 1'b0);
        send(9.0, 10.0, 2'd1, 1'b1);
        repeat (2) @(negedge clk);
        chk("x_err_clean", 64'(x_err), 64'd0);
        done_pulse();

        // out-of-range x on beat 2
        f = '0;
        f.n = 5'd3;
        f = put(f, 0, 0.5, 0.25, 2'd1);
        f = put(f, 1, 0.75, 1.25, XCHK ? 2'd0 : 2'd3);
        f = put(f, 2, 2.0, 4.0, 2'd0);
        exp_q.push_back(f);
        send(0.5, 0.25, 2'd1, 1'b0);
        send(0.75, 1.25, 2'd3, 1'b0);
        send(2.0, 4.0, 2'd0, 1'b1);
        repeat (2) @(negedge clk);
        chk("x_err_set", 64'(x_err), 64'(XCHK));
        done_pulse();
        f = '0;
        f.n = 5'd1;
        f = put(f, 0, 6.0, 6.5, 2'd1);
        exp_q.push_back(f);
        send(6.0, 6.5, 2'd1, 1'b1);
        repeat (2) @(negedge clk);
        chk("x_err_sticky", 64'(x_err), 64'(XCHK));

        repeat (3) @(negedge clk);
        chk("frames_outstanding", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
